// File: rtl/fp_normalize_pack.sv
// Normalise a raw sign/exponent/25-bit mantissa one bit position per clock,
// then pack it as an IEEE-754 single, with valid/ready on both sides.
module fp_normalize_pack #(
    parameter bit FLUSH_DENORMAL = 1'b0,
    parameter bit ZERO_SIGN_POS  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        raw_sign,
    input  logic [7:0]  raw_exponent,
    input  logic [24:0] raw_mantissa,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_result,
    output logic        zero,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t      state_reg, state_next;
    logic        sign_reg, sign_next;
    logic [8:0]  exp_reg, exp_next;
    logic [24:0] mant_reg, mant_next;
    logic [31:0] result_reg, result_next;
    logic        zero_reg, zero_next;
    logic        overflow_reg, overflow_next;
    logic        underflow_reg, underflow_next;
    logic        out_valid_reg, out_valid_next;
    logic [8:0]  exp_inc;

    assign exp_inc = exp_reg + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            sign_reg      <= 1'b0;
            exp_reg       <= 9'd0;
            mant_reg      <= 25'd0;
            result_reg    <= 32'd0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sign_reg      <= sign_next;
            exp_reg       <= exp_next;
            mant_reg      <= mant_next;
            result_reg    <= result_next;
            zero_reg      <= zero_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sign_next      = sign_reg;
        exp_next       = exp_reg;
        mant_next      = mant_reg;
        result_next    = result_reg;
        zero_next      = zero_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sign_next = raw_sign;
                    exp_next  = {1'b0, raw_exponent};
                    mant_next = raw_mantissa;
                    if (raw_exponent == 8'hFF) begin
                        // Inf/NaN passes straight through; any payload becomes a quiet NaN
                        state_next     = DONE;
                        result_next    = {raw_sign, 8'hFF,
                                          (|raw_mantissa[22:0]) ? 23'h400000 : 23'h0};
                        zero_next      = 1'b0;
                        overflow_next  = 1'b0;
                        underflow_next = 1'b0;
                    end else begin
                        state_next = NORM;
                    end
                end
            end
            NORM: begin
                zero_next      = 1'b0;
                overflow_next  = 1'b0;
                underflow_next = 1'b0;
                if (mant_reg == 25'd0) begin
                    state_next  = DONE;
                    result_next = {(ZERO_SIGN_POS ? 1'b0 : sign_reg), 31'h0};
                    zero_next   = 1'b1;
                end else if (mant_reg[24]) begin
                    mant_next = mant_reg >> 1;
                    exp_next  = exp_inc;
                    if (exp_inc == 9'd255) begin
                        state_next    = DONE;
                        result_next   = {sign_reg, 8'hFF, 23'h0};
                        overflow_next = 1'b1;
                    end
                end else if (mant_reg[23]) begin
                    state_next  = DONE;
                    result_next = {sign_reg, exp_reg[7:0], mant_reg[22:0]};
                end else if (exp_reg <= 9'd1) begin
                    // Cannot shift further without leaving the normal range
                    state_next     = DONE;
                    underflow_next = 1'b1;
                    if (FLUSH_DENORMAL) begin
                        result_next = {sign_reg, 31'h0};
                        zero_next   = 1'b1;
                    end else begin
                        result_next = {sign_reg, 8'h00, mant_reg[22:0]};
                    end
                end else begin
                    mant_next = mant_reg << 1;
                    exp_next  = exp_reg - 9'd1;
                end
            end
            DONE: begin
                // out_valid rises one clock after entering DONE, drops on handshake
                if (!out_valid_reg) begin
                    out_valid_next = 1'b1;
                end else if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign fp_result = result_reg;
    assign zero      = zero_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed bench for fp_normalize_pack: default instance plus a flushing,
// signed-zero instance driven by the same stimulus.
module tb_fp_normalize_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        raw_sign;
    logic [7:0]  raw_exponent;
    logic [24:0] raw_mantissa;
    logic        out_ready;

    logic        in_ready, out_valid, zero, overflow, underflow;
    logic [31:0] fp_result;
    logic        f_in_ready, f_out_valid, f_zero, f_overflow, f_underflow;
    logic [31:0] f_fp_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_normalize_pack dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .raw_sign(raw_sign), .raw_exponent(raw_exponent), .raw_mantissa(raw_mantissa),
        .out_valid(out_valid), .out_ready(out_ready),
        .fp_result(fp_result), .zero(zero), .overflow(overflow), .underflow(underflow)
    );

    fp_normalize_pack #(.FLUSH_DENORMAL(1'b1), .ZERO_SIGN_POS(1'b0)) dut_flush (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(f_in_ready),
        .raw_sign(raw_sign), .raw_exponent(raw_exponent), .raw_mantissa(raw_mantissa),
        .out_valid(f_out_valid), .out_ready(out_ready),
        .fp_result(f_fp_result), .zero(f_zero), .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // flags are packed {zero, overflow, underflow}
    task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [24:0] m, input int exp_lat,
                          input logic [31:0] exp_res, input logic [2:0] exp_flags,
                          input logic [31:0] exp_fres, input logic [2:0] exp_fflags,
                          input int hold);
        int lat;
        logic [31:0] first_res;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        raw_sign     = s;
        raw_exponent = e;
        raw_mantissa = m;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, fp_result, exp_res);
        check({tag, "_flags"}, {29'd0, zero, overflow, underflow}, {29'd0, exp_flags});
        check({tag, "_fres"}, f_fp_result, exp_fres);
        check({tag, "_fflags"}, {29'd0, f_zero, f_overflow, f_underflow}, {29'd0, exp_fflags});
        first_res = fp_result;
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            check({tag, "_hold_res"}, fp_result, first_res);
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
        $display("txn %-8s s=%0b e=%h m=%h lat=%0d res=%h flags=%b fres=%h fflags=%b",
                 tag, s, e, m, lat, fp_result, {zero, overflow, underflow},
                 f_fp_result, {f_zero, f_overflow, f_underflow});
    endtask

    initial begin
        int seen;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        raw_sign     = 1'b0;
        raw_exponent = 8'h00;
        raw_mantissa = 25'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out", {fp_result[31:4], out_valid, zero, overflow, underflow}, 32'd0);
        check("rst_res_low", {28'd0, fp_result[3:0]}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("carry",   1'b0, 8'h7F, 25'h1800000, 3,  32'h40400000, 3'b000, 32'h40400000, 3'b000, 0);
        run_op("normal",  1'b0, 8'h7F, 25'h0800000, 2,  32'h3F800000, 3'b000, 32'h3F800000, 3'b000, 5);
        run_op("cancel",  1'b0, 8'h7F, 25'h0000001, 25, 32'h34000000, 3'b000, 32'h34000000, 3'b000, 0);
        run_op("zero",    1'b1, 8'h7F, 25'h0000000, 2,  32'h00000000, 3'b100, 32'h80000000, 3'b100, 0);
        run_op("ovf",     1'b0, 8'hFE, 25'h1000000, 2,  32'h7F800000, 3'b010, 32'h7F800000, 3'b010, 0);
        run_op("denorm",  1'b0, 8'h01, 25'h0400000, 2,  32'h00400000, 3'b001, 32'h00000000, 3'b101, 0);
        run_op("den_sh",  1'b0, 8'h03, 25'h0100000, 4,  32'h00400000, 3'b001, 32'h00000000, 3'b101, 0);
        run_op("den_e0",  1'b1, 8'h00, 25'h0000123, 2,  32'h80000123, 3'b001, 32'h80000000, 3'b101, 0);
        run_op("lshift2", 1'b1, 8'h80, 25'h0200000, 4,  32'hBF000000, 3'b000, 32'hBF000000, 3'b000, 2);
        run_op("nan",     1'b1, 8'hFF, 25'h0000001, 1,  32'hFFC00000, 3'b000, 32'hFFC00000, 3'b000, 0);
        run_op("inf",     1'b0, 8'hFF, 25'h1000000, 1,  32'h7F800000, 3'b000, 32'h7F800000, 3'b000, 0);

        // Abort a long cancellation midway through normalisation
        raw_sign     = 1'b0;
        raw_exponent = 8'h7F;
        raw_mantissa = 25'h0000001;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("midnorm_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out", {28'd0, out_valid, zero, overflow, underflow}, 32'd0);
        check("midrst_res", fp_result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_pulse", seen, 0);
        $display("txn reset-mid-norm out_valid_pulses=%0d in_ready=%0b", seen, in_ready);
        run_op("after",   1'b0, 8'h7F, 25'h0800000, 2,  32'h3F800000, 3'b000, 32'h3F800000, 3'b000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_normalize_pack.md
Name: fp_normalize_pack

Overview:
- Back end of the FPU add path. Accepts the raw sign, exponent and 25-bit mantissa produced by the shifter/adder stage.
- Normalises the mantissa iteratively, one bit position per clock, then packs the value into an IEEE-754 single-precision word.
- Uses a valid/ready handshake on both sides, so it can sit between the add stage and the result register/bus.

Parameters:
- FLUSH_DENORMAL, 0: when 1, denormal results are replaced by a zero of the same sign. underflow is still flagged.
- ZERO_SIGN_POS, 1: when 1, an exact-zero mantissa packs as +0. When 0, it packs as ±0 using raw_sign.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  raw operand valid.
- in_ready  out  1  block can accept a raw operand.
- raw_sign  in  1  raw result sign.
- raw_exponent  in  8  raw biased exponent.
- raw_mantissa  in  25  raw mantissa. Bit 24 is the carry-out, bit 23 is the hidden-bit position.
- out_valid  out  1  packed result valid.
- out_ready  in  1  consumer accepts the result.
- fp_result  out  32  packed IEEE-754 single.
- zero  out  1  result is ±0.
- overflow  out  1  result saturated to ±inf.
- underflow  out  1  result is denormal or was flushed to zero.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state IDLE; out_valid, fp_result, zero, overflow and underflow all 0.
  - in_ready = 1 while reset is asserted and after it is released.
  - Reset mid-operation aborts the work in progress; nothing is emitted.
- States: IDLE, NORM, DONE. in_ready = (state == IDLE), combinational.
- IDLE:
  - When in_valid && in_ready, latch sign, exponent (E, 8 bits) and mantissa (M, 25 bits), then go to NORM.
  - If raw_exponent == 8'hFF, go straight to DONE with fp_result = {sign, 8'hFF, (|M[22:0]) ? 23'h400000 : 23'h0}. No flags are set.
- NORM: exactly one action per cycle, evaluated in this priority order:
  1. M == 0: go to DONE. Result is zero with sign per ZERO_SIGN_POS; zero = 1.
  2. M[24] = 1: M <= M >> 1 (shifted-out bit is truncated); E <= E + 1.
     - If E + 1 == 255, go to DONE with fp_result = {sign, 8'hFF, 23'h0} and overflow = 1.
  3. M[23] = 1: go to DONE with fp_result = {sign, E, M[22:0]}.
  4. E <= 1 (covers denormal inputs with E == 0): go to DONE, underflow = 1.
     - FLUSH_DENORMAL = 0: fp_result = {sign, 8'h00, M[22:0]}.
     - FLUSH_DENORMAL = 1: fp_result = {sign, 31'h0}, zero = 1.
  5. Otherwise: M <= M << 1; E <= E - 1.
- Exponent arithmetic uses a 9-bit internal width. Wrap-around is impossible given the priority order above.
- DONE:
  - out_valid = 1. fp_result and flags stay stable until out_ready is sampled high.
  - Then out_valid returns to 0 and the state returns to IDLE.
  - A new input can be accepted no earlier than the cycle after the handshake (in_ready is 0 throughout NORM and DONE).
- Latency from the accept edge to out_valid high:
  - N + 1 clocks, where N is the number of NORM cycles.
  - Already-normal input: 2 clocks. Carry case: 3 clocks. Worst-case cancellation: 25 clocks.
- Rounding is truncation only, matching the add stage.
- Flags are mutually exclusive except zero + underflow when a denormal is flushed.

Test Plan:
- Carry: sign 0, exp 8'h7F, mant 25'h1800000 -> fp_result 32'h40400000 (3.0), out_valid 3 clocks after accept, no flags.
- Already normal: exp 8'h7F, mant 25'h0800000 -> 32'h3F800000, out_valid 2 clocks after accept. Hold out_ready low 5 cycles -> result stable, in_ready stays 0 until the handshake.
- Cancellation: exp 8'h7F, mant 25'h0000001 -> 23 left shifts, 32'h34000000, latency 25 clocks.
- Zero and overflow:
  - sign 1, mant 0 -> 32'h00000000, zero = 1 (ZERO_SIGN_POS = 1).
  - exp 8'hFE, mant 25'h1000000 -> 32'h7F800000, overflow = 1.
- Denormal:
  - exp 8'h01, mant 25'h0400000 -> 32'h00400000, underflow = 1.
  - With FLUSH_DENORMAL = 1 -> 32'h00000000, zero = 1, underflow = 1.
- Reset mid-NORM during the cancellation case -> outputs clear immediately, in_ready = 1, no out_valid pulse. The next input (exp 8'h7F, mant 25'h0800000) produces 32'h3F800000 normally.
